bus_arbiter: RTL

Two-master arbiter and address decoder for the shared system bus. It sits between the CPU core (master 0) and a second bus master (master 1, e.g. DMA or debug port) on one side, and the ROM/SRAM/UART/timer slaves on the other. It serialises transactions with round-robin fairness, drives the one-hot slave chip-enables from the address, and forwards the slave grant and read data back to the winner. Transactions to unmapped addresses, and transactions the slave never grants, complete with an error response.

---
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and address decoder for the shared system bus.
// Latency: a request seen in IDLE reaches the slave next cycle; a combinational slave completes in that same cycle.
// Backpressure: a master holds REQ until its one-cycle GNT; there is one IDLE cycle between transactions and a slave stall ends in ERR after TIMEOUT cycles.
//
// Ports:
//   i_CLK, i_RSTn             clock, asynchronous active-low reset
//   i_Mx_REQ/ADDR/WDATA/WE/RE/HB   master x request, held until o_Mx_GNT
//   o_Mx_GNT/RDATA/ERR        master x completion pulse, read data, error flag
//   o_S_*                     request forwarded to the slaves, o_S_CE one-hot by ADDR[31:28]
//   i_S_GNT, i_S_RDATA        OR of slave grants, muxed slave read data
module bus_arbiter #(
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  input  logic        i_M0_REQ,
  input  logic [31:0] i_M0_ADDR,
  input  logic [31:0] i_M0_WDATA,
  input  logic        i_M0_WE,
  input  logic        i_M0_RE,
  input  logic [1:0]  i_M0_HB,
  output logic        o_M0_GNT,
  output logic [31:0] o_M0_RDATA,
  output logic        o_M0_ERR,
  input  logic        i_M1_REQ,
  input  logic [31:0] i_M1_ADDR,
  input  logic [31:0] i_M1_WDATA,
  input  logic        i_M1_WE,
  input  logic        i_M1_RE,
  input  logic [1:0]  i_M1_HB,
  output logic        o_M1_GNT,
  output logic [31:0] o_M1_RDATA,
  output logic        o_M1_ERR,
  output logic [31:0] o_S_ADDR,
  output logic [31:0] o_S_WDATA,
  output logic        o_S_WE,
  output logic        o_S_RE,
  output logic        o_S_REQ,
  output logic [1:0]  o_S_HB,
  output logic [7:0]  o_S_CE,
  input  logic        i_S_GNT,
  input  logic [31:0] i_S_RDATA
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

  localparam logic [4:0] NSLV_L   = 5'(NSLV);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       owner;     // master currently holding the bus
  logic       last;      // master served most recently, loses the next tie
  logic [7:0] cnt;       // ACCESS cycles spent without a slave grant
  logic [2:0] sel;       // slave region decoded when the owner was chosen

  // Arbitration and decode of the would-be winner, only acted on in IDLE.
  logic       any_req;
  logic       winner;
  logic [3:0] win_region;
  logic       win_hit;

  always_comb begin
    any_req    = i_M0_REQ | i_M1_REQ;
    winner     = (i_M0_REQ && i_M1_REQ) ? ~last : i_M1_REQ;
    win_region = winner ? i_M1_ADDR[31:28] : i_M0_ADDR[31:28];
    win_hit    = ({1'b0, win_region} < NSLV_L);
  end

  // Owner's live request fields; masters keep them stable until GNT.
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic        own_we;
  logic        own_re;
  logic [1:0]  own_hb;

  always_comb begin
    own_addr  = owner ? i_M1_ADDR  : i_M0_ADDR;
    own_wdata = owner ? i_M1_WDATA : i_M0_WDATA;
    own_we    = owner ? i_M1_WE    : i_M0_WE;
    own_re    = owner ? i_M1_RE    : i_M0_RE;
    own_hb    = owner ? i_M1_HB    : i_M0_HB;
  end

  logic in_access;
  logic done_ok;
  logic err_rsp;

  always_comb begin
    in_access = (state == ACCESS);
    // A slave grant is only honoured while the bus is actually in ACCESS.
    done_ok   = in_access & i_S_GNT;
    err_rsp   = (state == ERR);
  end

  // Slave side: everything is zero outside ACCESS.
  always_comb begin
    o_S_REQ   = in_access;
    o_S_ADDR  = in_access ? own_addr  : 32'd0;
    o_S_WDATA = in_access ? own_wdata : 32'd0;
    o_S_WE    = in_access & own_we;
    o_S_RE    = in_access & own_re;
    o_S_HB    = in_access ? own_hb : 2'd0;
    o_S_CE    = in_access ? (8'd1 << sel) : 8'd0;
  end

  // Master side: only the owner ever sees GNT, ERR or read data.
  always_comb begin
    o_M0_GNT   = (done_ok | err_rsp) & ~owner;
    o_M1_GNT   = (done_ok | err_rsp) &  owner;
    o_M0_ERR   = err_rsp & ~owner;
    o_M1_ERR   = err_rsp &  owner;
    o_M0_RDATA = (done_ok && !owner) ? i_S_RDATA : 32'd0;
    o_M1_RDATA = (done_ok &&  owner) ? i_S_RDATA : 32'd0;
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= 8'd0;
      sel   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner;
            sel   <= win_region[2:0];
            cnt   <= 8'd0;
            state <= win_hit ? ACCESS : ERR;
          end
        end
        ACCESS: begin
          // A grant in the final allowed cycle still completes normally.
          if (i_S_GNT) begin
            last  <= owner;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERR: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
